// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
package md_pkg;

  // EX-stage operation codes; 7 is reserved and behaves as NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Radix-2 iterations needed for 32-bit operands.
  localparam int DIV_ITER = 32;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// 32-bit unsigned restoring divider, one quotient bit per step.
// quot/rem present the value after the current cycle's step so the
// caller can retire the result on the edge of the final step.
module md_div_iter (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] q_r;
  logic [31:0] r_r;
  logic [31:0] d_r;
  logic [32:0] trial_s;
  logic [32:0] diff_s;
  logic [31:0] q_nxt_s;
  logic [31:0] r_nxt_s;

  // One restoring iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial_s = {r_r, q_r[31]};
    diff_s  = trial_s - {1'b0, d_r};
    q_nxt_s = q_r;
    r_nxt_s = r_r;
    if (step) begin
      if (!diff_s[32]) begin
        r_nxt_s = diff_s[31:0];
        q_nxt_s = {q_r[30:0], 1'b1};
      end else begin
        r_nxt_s = trial_s[31:0];
        q_nxt_s = {q_r[30:0], 1'b0};
      end
    end else begin
      q_nxt_s = q_r;
      r_nxt_s = r_r;
    end
  end

  // Operand load or iteration update of the divider registers.
  always_ff @(posedge clk) begin
    if (load) begin
      q_r <= dividend;
      r_r <= 32'd0;
      d_r <= divisor;
    end else begin
      q_r <= q_nxt_s;
      r_r <= r_nxt_s;
    end
  end

  assign quot = q_nxt_s;
  assign rem  = r_nxt_s;

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the execute stage.
module md_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  import md_pkg::*;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_ITER - 1);

  md_state_e         state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [31:0]       hi_r, lo_r;
  logic [63:0]       prod_r;
  logic              neg_q_r, neg_r_r;

  logic              acc_s, signed_s, is_mul_s, is_div_s, wr_hi_s, wr_lo_s;
  logic              mul_done_s, div_done_s, div_step_s;
  logic [63:0]       mul_a_s, mul_b_s, prod_s;
  logic [31:0]       div_a_s, div_b_s, quot_s, rem_s, q_fix_s, r_fix_s;

  // Decode the EX op into accept actions; only IDLE without cancel accepts.
  always_comb begin
    acc_s    = op_valid && !cancel && (state_r == ST_IDLE);
    signed_s = 1'b0;
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    wr_hi_s  = 1'b0;
    wr_lo_s  = 1'b0;
    if (acc_s) begin
      case (op)
        MD_MULT:  begin is_mul_s = 1'b1; signed_s = 1'b1; end
        MD_MULTU: begin is_mul_s = 1'b1; end
        MD_DIV:   begin is_div_s = (src2 != 32'd0); signed_s = 1'b1; end
        MD_DIVU:  begin is_div_s = (src2 != 32'd0); end
        MD_MTHI:  begin wr_hi_s = 1'b1; end
        MD_MTLO:  begin wr_lo_s = 1'b1; end
        default:  begin is_mul_s = 1'b0; end
      endcase
    end else begin
      is_mul_s = 1'b0;
    end
  end

  // Operand shaping: sign/zero extension for multiply, magnitudes for divide.
  always_comb begin
    mul_a_s = signed_s ? {{32{src1[31]}}, src1} : {32'd0, src1};
    mul_b_s = signed_s ? {{32{src2[31]}}, src2} : {32'd0, src2};
    prod_s  = mul_a_s * mul_b_s;
    div_a_s = signed_s ? abs32(src1) : src1;
    div_b_s = signed_s ? abs32(src2) : src2;
    q_fix_s = neg_q_r ? (32'd0 - quot_s) : quot_s;
    r_fix_s = neg_r_r ? (32'd0 - rem_s) : rem_s;
  end

  // Next-state and counter; cancel wins over completion.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mul_done_s  = 1'b0;
    div_done_s  = 1'b0;
    div_step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_mul_s) begin
          state_nxt_s = ST_MUL;
          cnt_nxt_s   = MUL_LOAD;
        end else if (is_div_s) begin
          state_nxt_s = ST_DIV;
          cnt_nxt_s   = DIV_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 6'd0;
        end else if (cnt_r == 6'd0) begin
          state_nxt_s = ST_IDLE;
          mul_done_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 6'd1;
        end
      end
      ST_DIV: begin
        div_step_s = !cancel;
        if (cancel) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 6'd0;
        end else if (cnt_r == 6'd0) begin
          state_nxt_s = ST_IDLE;
          div_done_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 6'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 6'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // HI/LO, registered product and divide sign flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      prod_r  <= 64'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      if (is_mul_s) begin
        prod_r <= prod_s;
      end
      if (is_div_s) begin
        neg_q_r <= signed_s & (src1[31] ^ src2[31]);
        neg_r_r <= signed_s & src1[31];
      end
      if (wr_hi_s) begin
        hi_r <= src1;
      end
      if (wr_lo_s) begin
        lo_r <= src1;
      end
      if (mul_done_s) begin
        hi_r <= prod_r[63:32];
        lo_r <= prod_r[31:0];
      end
      if (div_done_s) begin
        hi_r <= r_fix_s;
        lo_r <= q_fix_s;
      end
    end
  end

  md_div_iter u_div (
    .clk      (clk),
    .load     (is_div_s),
    .step     (div_step_s),
    .dividend (div_a_s),
    .divisor  (div_b_s),
    .quot     (quot_s),
    .rem      (rem_s)
  );

  assign busy    = (state_r != ST_IDLE);
  assign stall   = busy & (op_valid | rd_hi | rd_lo) & ~cancel;
  assign hi      = hi_r;
  assign lo      = lo_r;
  assign rd_data = rd_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random traffic
// against a transaction-level model of HI/LO and busy time.
module tb_md_ctrl;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;

  logic        clk = 1'b0;
  logic        resetn, op_valid, cancel, rd_hi, rd_lo;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stall, busy;
  logic [31:0] hi, lo, rd_data;

  always #5 clk = ~clk;

  md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .src1(src1), .src2(src2), .cancel(cancel), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural HI/LO, cycles of busy left, pending result.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem;
  logic        last_busy, last_stall;
  logic [31:0] last_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic h, input logic l);
    op_valid = v; op = o; src1 = a; src2 = b; cancel = c; rd_hi = h; rd_lo = l;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Apply one clock edge of the architectural rules to the model.
  task automatic model_edge();
    longint sa, sb, q, r;
    logic [63:0] ua, ub, up;
    if (!resetn) begin
      m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
    end else if (m_rem != 0) begin
      if (cancel) begin
        m_rem = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (op_valid && !cancel) begin
      sa = longint'($signed(src1));
      sb = longint'($signed(src2));
      ua = {32'd0, src1};
      ub = {32'd0, src2};
      case (op)
        3'd1: begin q = sa * sb; p_hi = q[63:32]; p_lo = q[31:0]; m_rem = MUL_LAT; end
        3'd2: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; m_rem = MUL_LAT; end
        3'd3: if (src2 != 32'd0) begin
                q = sa / sb; r = sa % sb;
                p_lo = q[31:0]; p_hi = r[31:0]; m_rem = DIV_ITER;
              end
        3'd4: if (src2 != 32'd0) begin
                up = ua / ub; p_lo = up[31:0];
                up = ua % ub; p_hi = up[31:0]; m_rem = DIV_ITER;
              end
        3'd5: m_hi = src1;
        3'd6: m_lo = src1;
        default: ;
      endcase
    end
  endtask

  // Check outputs mid-cycle against the model, then advance one clock.
  task automatic step();
    logic exp_busy, exp_stall;
    #1;
    exp_busy  = (m_rem != 0);
    exp_stall = exp_busy && (op_valid || rd_hi || rd_lo) && !cancel;
    check_val("busy", {31'd0, busy}, {31'd0, exp_busy});
    check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
    check_val("hi", hi, m_hi);
    check_val("lo", lo, m_lo);
    check_val("rd_data", rd_data, rd_hi ? m_hi : m_lo);
    last_busy = busy; last_stall = stall; last_rd = rd_data;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int guard;
    resetn = 1'b0;
    idle();
    m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; p_hi = 32'd0; p_lo = 32'd0;
    @(posedge clk);
    model_edge();
    #1;
    step();
    resetn = 1'b1;
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);

    // MULT -3 * 5 then MULTU with the same operands.
    drive(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0); step();
    idle(); n = 0;
    for (int i = 0; i < 4; i++) begin step(); if (last_busy) n++; end
    check_val("mult_busy_cycles", n, MUL_LAT);
    check_val("mult_hi", hi, 32'hFFFF_FFFF);
    check_val("mult_lo", lo, 32'hFFFF_FFF1);
    drive(1'b1, 3'd2, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0); step();
    idle(); for (int i = 0; i < 4; i++) step();
    check_val("multu_hi", hi, 32'h0000_0004);
    check_val("multu_lo", lo, 32'hFFFF_FFF1);

    // DIV -7 / 2: busy exactly 32 cycles.
    drive(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0); step();
    idle(); n = 0; guard = 0;
    do begin step(); if (last_busy) n++; guard++; end while (last_busy && guard < 100);
    check_val("div_busy_cycles", n, 32);
    check_val("div_lo", lo, 32'hFFFF_FFFD);
    check_val("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 7.
    drive(1'b1, 3'd4, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0); step();
    idle(); for (int i = 0; i < 34; i++) step();
    check_val("divu_lo", lo, 32'd14);
    check_val("divu_hi", hi, 32'd2);

    // Signed overflow corner.
    drive(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0); step();
    idle(); for (int i = 0; i < 34; i++) step();
    check_val("ovf_lo", lo, 32'h8000_0000);
    check_val("ovf_hi", hi, 32'd0);

    // Divide by zero leaves HI/LO untouched and never goes busy.
    drive(1'b1, 3'd5, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'd6, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'd4, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0); step();
    idle(); step();
    check_val("div0_busy", {31'd0, last_busy}, 32'd0);
    check_val("div0_hi", hi, 32'h11);
    check_val("div0_lo", lo, 32'h22);

    // MTHI/MTLO; a read in the same cycle returns the old value.
    drive(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0); step();
    check_val("mthi_old_read", last_rd, 32'h11);
    drive(1'b1, 3'd6, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0); step();
    idle(); step();
    check_val("mthi_hi", hi, 32'hDEAD_BEEF);
    check_val("mtlo_lo", lo, 32'h1234);

    // MFHI one cycle after a DIVU accept stalls 31 cycles, then sees the remainder.
    drive(1'b1, 3'd4, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0); step();
    idle(); step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    n = 0; guard = 0;
    do begin step(); if (last_stall) n++; guard++; end while (last_stall && guard < 100);
    check_val("mfhi_stall_cycles", n, 31);
    check_val("mfhi_data", last_rd, 32'd2);

    // Cancel in the middle of a divide; op with cancel in IDLE is dropped.
    drive(1'b1, 3'd5, 32'hAAAA, 32'd0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'd6, 32'hBBBB, 32'd0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0); step();
    idle(); for (int i = 0; i < 9; i++) step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0); step();
    idle(); step();
    check_val("cancel_busy", {31'd0, last_busy}, 32'd0);
    check_val("cancel_hi", hi, 32'hAAAA);
    check_val("cancel_lo", lo, 32'hBBBB);
    drive(1'b1, 3'd5, 32'h5555, 32'd0, 1'b1, 1'b0, 1'b0); step();
    idle(); step();
    check_val("cancel_idle_hi", hi, 32'hAAAA);

    // Reset during a multiply.
    drive(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0); step();
    idle(); resetn = 1'b0; step();
    resetn = 1'b1; step();
    check_val("rst_mul_busy", {31'd0, last_busy}, 32'd0);
    check_val("rst_mul_hi", hi, 32'd0);
    check_val("rst_mul_lo", lo, 32'd0);

    // Back-to-back MULT: second one waits out the first.
    drive(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    n = 0; guard = 0;
    do begin step(); if (last_stall) n++; guard++; end while (last_stall && guard < 100);
    check_val("b2b_stall_cycles", n, MUL_LAT);
    check_val("b2b_first_lo", lo, 32'd12);
    idle(); for (int i = 0; i < MUL_LAT; i++) step();
    check_val("b2b_second_lo", lo, 32'd42);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      resetn   = ($urandom_range(0, 199) != 0);
      op_valid = ($urandom_range(0, 1) != 0);
      op       = 3'($urandom_range(0, 7));
      src1     = rnd32();
      src2     = rnd32();
      cancel   = ($urandom_range(0, 39) == 0);
      rd_hi    = ($urandom_range(0, 3) == 0);
      rd_lo    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Sequencer for the multiply/divide resource and owner of the HI/LO architectural registers, used by the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs the multi-cycle operation. It raises a pipeline stall when EX issues a new op or an MFHI/MFLO read while a multiply or divide is still in flight. It also aborts in-flight work when an exception flush arrives.

Parameters:
MUL_LAT, 2, cycles busy for MULT/MULTU (1..4)
DIV_ITER, 32, radix-2 divider iterations (fixed 32 for 32-bit operands)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
op_valid  in  1  EX presents an md op this cycle
op  in  3  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO (7 reserved = NONE)
src1  in  32  rs value (dividend/multiplicand; MTHI/MTLO data)
src2  in  32  rt value (divisor/multiplier)
cancel  in  1  exception flush: kill EX op and in-flight operation
rd_hi  in  1  MFHI in EX
rd_lo  in  1  MFLO in EX
stall  out  1  freeze IF/ID/EX this cycle
busy  out  1  multiply/divide in flight
hi  out  32  HI register
lo  out  32  LO register
rd_data  out  32  rd_hi ? hi : lo (combinational)

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, hi=0, lo=0, cnt=0, busy=0, stall=0. Reset mid-operation discards the operation; HI/LO are zeroed.
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- Accept = op_valid & !cancel & state==IDLE & op in 1..6.
- MTHI/MTLO accepted:
  - hi (or lo) <= src1 at that edge.
  - State stays IDLE.
  - No stall.
- MULT/MULTU accepted:
  - Latch the 64-bit product (signed / unsigned), state->MUL, cnt<=MUL_LAT-1.
  - In MUL: if cnt==0, {hi,lo}<=product and state->IDLE; else cnt--.
  - busy is high for exactly MUL_LAT cycles after the accept edge.
- DIV/DIVU accepted with src2 != 0:
  - Load the divider with |src1|, |src2| (signed) or raw values (unsigned).
  - Record the signs; state->DIV, cnt<=DIV_ITER-1.
  - Each DIV cycle performs one restoring iteration.
  - At cnt==0: lo<=quotient, hi<=remainder after sign fixup, state->IDLE.
  - Sign fixup: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - busy is high for exactly 32 cycles.
- DIV/DIVU with src2==0:
  - HI/LO unchanged, state stays IDLE, no busy.
  - The op is architecturally complete on the accept edge.
- stall = busy & (op_valid | rd_hi | rd_lo) & !cancel.
  - A stalled op is not accepted; EX holds it. It is accepted on the first cycle with busy=0.
  - The completion edge (state->IDLE) deasserts busy the next cycle. A waiting op or read proceeds then, so a read sees the new HI/LO.
- cancel:
  - An op presented together with cancel is never accepted.
  - If busy, state->IDLE at the next edge, HI/LO unchanged, counter cleared.
  - cancel on the completion cycle takes priority: no write.
- rd_data is combinational. When an MTHI/MTLO and a read coincide in IDLE, the read returns the pre-write value.
- Width rules:
  - Product is 64-bit; MULT uses sign-extended operands.
  - Quotient/remainder are 32-bit.
  - Signed overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- op 0/7 with op_valid is ignored: no accept, no stall unless busy.

Decomposition:
- Shared package md_pkg:
  - op encodings (MD_NONE..MD_MTLO)
  - state encodings (ST_IDLE, ST_MUL, ST_DIV)
  - constant DIV_ITER
- Sub-module md_div_iter:
  - 32-bit restoring radix-2 divider
  - ports: clk, load, step, dividend, divisor, quot, rem
  - one iteration per step; unsigned only
- md_ctrl performs the abs/sign fixup and the multiply; the multiply is a registered product.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=5 -> busy 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV src1=0xFFFFFFF9 (-7), src2=2 -> busy exactly 32 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 with hi=0x11, lo=0x22 -> no busy, hi/lo unchanged; MTHI 0xDEADBEEF then MTLO 0x1234 -> hi=0xDEADBEEF, lo=0x1234, stall never high.
- MFHI (rd_hi=1) issued 1 cycle after DIV accept -> stall high 31 cycles; on the first unstalled cycle rd_data = remainder.
- cancel at DIV cycle 10 with prior hi=0xAAAA, lo=0xBBBB -> state IDLE next cycle, busy=0, hi/lo unchanged; op_valid+cancel in IDLE -> not accepted.
- resetn=0 during MUL -> next cycle busy=0, hi=lo=0; back-to-back MULT while busy -> stall until first MULT completes, then second completes MUL_LAT later.
